// File: rtl/queue_wr_arbiter.sv
// rtl/queue_wr_arbiter.sv - round-robin write-port arbiter for a shared queue
// Two producers share one queue write port; occupancy tracking gates grants at full.
module queue_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  reqA_i,
   input  logic [DATA_WIDTH-1:0] dataA_i,
   input  logic                  reqB_i,
   input  logic [DATA_WIDTH-1:0] dataB_i,
   input  logic                  rd_i,
   output logic                  grantA_o,
   output logic                  grantB_o,
   output logic                  sel_o,
   output logic                  wr_en_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic             r_prio;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_grant_a;
   logic w_grant_b;
   logic w_wr_en;
   logic w_sel;
   logic w_pop;

   // Flags come from the registered count only, so they never glitch with requests.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // rst_i gates the grants directly so an in-flight grant drops within the cycle.
   assign w_grant_a = ~rst_i & ~w_full & reqA_i & (~reqB_i | ~r_prio);
   assign w_grant_b = ~rst_i & ~w_full & reqB_i & (~reqA_i |  r_prio);
   assign w_wr_en   = w_grant_a | w_grant_b;
   assign w_sel     = w_grant_b | (~w_wr_en & r_prio & ~rst_i);
   assign w_pop     = rd_i & ~w_empty;

   genvar g;
   generate
      for (g = 0; g < DATA_WIDTH; g++) begin : g_mux
         assign wr_data_o[g] = w_sel ? dataB_i[g] : dataA_i[g];
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_prio  <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_grant_a)
            r_prio <= 1'b1;
         else if (w_grant_b)
            r_prio <= 1'b0;

         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign grantA_o = w_grant_a;
   assign grantB_o = w_grant_b;
   assign sel_o    = w_sel;
   assign wr_en_o  = w_wr_en;
   assign count_o  = r_count;
   assign full_o   = w_full;
   assign empty_o  = w_empty;

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// tb/tb_queue_wr_arbiter.sv - directed-vector bench for queue_wr_arbiter
module tb_queue_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       reqA, reqB, rd;
   logic [7:0] dataA, dataB;
   logic       grantA, grantB, sel, wr_en, full, empty;
   logic [7:0] wr_data;
   logic [3:0] count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   queue_wr_arbiter #(.DATA_WIDTH(8), .DEPTH(8), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .reqA_i(reqA), .dataA_i(dataA),
      .reqB_i(reqB), .dataB_i(dataB),
      .rd_i(rd),
      .grantA_o(grantA), .grantB_o(grantB), .sel_o(sel), .wr_en_o(wr_en),
      .wr_data_o(wr_data), .count_o(count), .full_o(full), .empty_o(empty)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic b, input logic r);
      reqA = a;
      reqB = b;
      rd   = r;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      reqA = 1'b1; reqB = 1'b1; rd = 1'b0;
      dataA = 8'h11; dataB = 8'h22;
      repeat (2) tick();
      chk("rst_grantA", grantA, 0);
      chk("rst_grantB", grantB, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_sel", sel, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);

      // single A write
      rst = 1'b0;
      drive(1, 0, 0);
      chk("t1_grantA", grantA, 1);
      chk("t1_grantB", grantB, 0);
      chk("t1_sel", sel, 0);
      chk("t1_wr_data", wr_data, 8'h11);
      tick();
      drive(0, 0, 0);
      chk("t1_count", count, 1);
      chk("t1_prio_sel", sel, 1);
      chk("t1_empty", empty, 0);

      // dual requests alternate from reset, then run on to full
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dataA = 8'hAA; dataB = 8'hBB;
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0);
         if (i == 4) chk("t2_count4", count, 4);
         chk($sformatf("t2_grantA_%0d", i), grantA, (i % 2 == 0));
         chk($sformatf("t2_grantB_%0d", i), grantB, (i % 2 == 1));
         chk($sformatf("t2_sel_%0d", i), sel, (i % 2 == 1));
         chk($sformatf("t2_data_%0d", i), wr_data, (i % 2 == 0) ? 8'hAA : 8'hBB);
         tick();
      end

      // full blocks writes
      drive(0, 1, 0);
      chk("t3_count", count, 8);
      chk("t3_full", full, 1);
      chk("t3_grantB", grantB, 0);
      chk("t3_wr_en", wr_en, 0);
      tick();
      chk("t3_count_hold", count, 8);

      // pop at full: no bypass, write next cycle
      drive(1, 0, 1);
      chk("t4_grantA_full", grantA, 0);
      tick();
      chk("t4_count7", count, 7);
      drive(1, 0, 0);
      chk("t4_grantA", grantA, 1);
      tick();
      chk("t4_count8", count, 8);

      // drain to empty, then pop while empty
      drive(0, 0, 1);
      repeat (8) tick();
      chk("t5_count0", count, 0);
      chk("t5_empty", empty, 1);
      tick();
      chk("t5_count0_pop", count, 0);
      chk("t5_empty_pop", empty, 1);
      drive(1, 0, 0);
      repeat (3) tick();
      chk("t5_count3", count, 3);
      drive(1, 0, 1);
      chk("t5_wr_pop_grant", grantA, 1);
      tick();
      chk("t5_count3_hold", count, 3);

      // async reset mid-stream at count 5; prio favours B after the A grants
      drive(1, 0, 0);
      repeat (2) tick();
      chk("t6_count5", count, 5);
      drive(1, 1, 0);
      chk("t6_grantB_pre", grantB, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_grantA_rst", grantA, 0);
      chk("t6_grantB_rst", grantB, 0);
      chk("t6_wr_en_rst", wr_en, 0);
      chk("t6_count_rst", count, 0);
      chk("t6_empty_rst", empty, 1);
      tick();
      rst = 1'b0;
      #1;
      chk("t6_grantA_post", grantA, 1);
      chk("t6_grantB_post", grantB, 0);
      chk("t6_sel_post", sel, 0);
      tick();
      chk("t6_count_post", count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
